// File: rtl/esc_arming_sequencer_pkg.sv
// Shared defines and types for the ESC arming sequencer: PWM frame period and state codes.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// This file is the common defines file. It must be compiled ahead of every
// file that uses `PWM_PERIOD_US or the ESC_STATE_* codes.
//   `PWM_PERIOD_US   : last value of the frame counter. A frame is
//                      `PWM_PERIOD_US+1 us_clk cycles long. The default of 249
//                      gives a 250 us frame (4 kHz) at a 1 MHz us_clk.
//   `ESC_STATE_*     : 2-bit encodings of the sequencer states.
`ifndef ESC_COMMON_DEFINES_SVH
`define ESC_COMMON_DEFINES_SVH
`define PWM_PERIOD_US      249
`define ESC_STATE_DISARMED 2'd0
`define ESC_STATE_ARMING   2'd1
`define ESC_STATE_ARMED    2'd2
`define ESC_STATE_FAULT    2'd3
`endif

package esc_arming_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = `ESC_STATE_DISARMED,
    ST_ARMING   = `ESC_STATE_ARMING,
    ST_ARMED    = `ESC_STATE_ARMED,
    ST_FAULT    = `ESC_STATE_FAULT
  } esc_state_t;

  localparam int unsigned FRAME_CNT_MAX = `PWM_PERIOD_US;
  localparam int unsigned FRAME_CNT_W   = $clog2(FRAME_CNT_MAX + 1);

endpackage

// File: rtl/rate_slew_limiter.sv
// One motor channel's rate register: steps the rate toward cmd on step_en.
// Latency: rate updates one us_clk edge after step_en or clr is sampled.
// Backpressure: none; cmd is only looked at when step_en is high.
//
// Ports: us_clk, resetn (async, active-low); clr forces rate to 0 and wins over
// step_en; step_en loads the next rate; cmd is the requested rate; rate is the
// registered output.
// Build option SLEW_LIMIT_EN: when defined, each step moves the rate by at most
// SLEW_STEP toward cmd. When undefined, each step copies cmd straight into rate.
module rate_slew_limiter #(
  parameter int RATE_WIDTH = 8,
  parameter int SLEW_STEP  = 4
) (
  input  logic                  us_clk,
  input  logic                  resetn,
  input  logic                  clr,
  input  logic                  step_en,
  input  logic [RATE_WIDTH-1:0] cmd,
  output logic [RATE_WIDTH-1:0] rate
);

  // A zero step would freeze the motors in ARMED.
  if (SLEW_STEP < 1) begin : g_bad_step
    $error("rate_slew_limiter: SLEW_STEP must be at least 1");
  end

  logic [RATE_WIDTH-1:0] rate_next;

`ifdef SLEW_LIMIT_EN
  // The extra bit holds the sign, so cmd < rate is detected without wrapping.
  logic [RATE_WIDTH:0] diff;
  logic [RATE_WIDTH:0] mag;

  always_comb begin
    diff = {1'b0, cmd} - {1'b0, rate};
    mag  = diff[RATE_WIDTH] ? (~diff + 1'b1) : diff;
    if (int'(mag) <= SLEW_STEP) begin
      // Close enough: land exactly on cmd, so the rate never overshoots.
      rate_next = cmd;
    end else if (diff[RATE_WIDTH]) begin
      rate_next = rate - RATE_WIDTH'(SLEW_STEP);
    end else begin
      rate_next = rate + RATE_WIDTH'(SLEW_STEP);
    end
  end
`else
  assign rate_next = cmd;
`endif

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      rate <= '0;
    end else if (clr) begin
      rate <= '0;
    end else if (step_en) begin
      rate <= rate_next;
    end
  end

endmodule

// File: rtl/esc_arming_sequencer.sv
// ESC arming sequencer: frame counter, DISARMED/ARMING/ARMED/FAULT FSM, four rate channels.
// Latency: a state change takes one us_clk edge; rates change only on frame_tick (disarm/fault zero them at once).
// Backpressure: none; cmds are sampled at frame_tick, arm_req/failsafe every cycle.
//
// Ports: us_clk (1 MHz), resetn (async, active-low); motor_N_cmd are the requested
// rates; arm_req and failsafe are levels; motor_N_rate are the registered rates
// to the PWM generator; armed is high in ARMED; state is the current state code;
// frame_tick pulses in the PWM latch cycle.
// Build option SLEW_LIMIT_EN: when defined, ARMED rates ramp by at most
// SLEW_STEP per frame. When undefined, ARMED rates follow cmd each frame.
module esc_arming_sequencer
  import esc_arming_sequencer_pkg::*;
#(
  parameter int RATE_WIDTH      = 8,
  parameter int ARM_HOLD_FRAMES = 100,
  parameter int SLEW_STEP       = 4
) (
  input  logic                  us_clk,
  input  logic                  resetn,
  input  logic [RATE_WIDTH-1:0] motor_1_cmd,
  input  logic [RATE_WIDTH-1:0] motor_2_cmd,
  input  logic [RATE_WIDTH-1:0] motor_3_cmd,
  input  logic [RATE_WIDTH-1:0] motor_4_cmd,
  input  logic                  arm_req,
  input  logic                  failsafe,
  output logic [RATE_WIDTH-1:0] motor_1_rate,
  output logic [RATE_WIDTH-1:0] motor_2_rate,
  output logic [RATE_WIDTH-1:0] motor_3_rate,
  output logic [RATE_WIDTH-1:0] motor_4_rate,
  output logic                  armed,
  output logic [1:0]            state,
  output logic                  frame_tick
);

  if (ARM_HOLD_FRAMES < 1) begin : g_bad_hold
    $error("esc_arming_sequencer: ARM_HOLD_FRAMES must be at least 1");
  end

  localparam int ARM_CNT_W = $clog2(ARM_HOLD_FRAMES + 1);

  // Frame counter. frame_tick is decoded from the counter register, so it
  // stays glitch-free and is 0 while resetn is low.
  logic [FRAME_CNT_W-1:0] frame_cnt;

  assign frame_tick = (frame_cnt == FRAME_CNT_W'(FRAME_CNT_MAX));

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      frame_cnt <= '0;
    end else if (frame_tick) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Arming FSM.
  esc_state_t           state_q, state_d;
  logic [ARM_CNT_W-1:0] arm_cnt_q, arm_cnt_d;
  logic                 cmds_zero;
  logic                 arm_done;

  assign cmds_zero = ~|{motor_1_cmd, motor_2_cmd, motor_3_cmd, motor_4_cmd};
  // True on the tick that completes the zero-throttle hold.
  assign arm_done  = (({1'b0, arm_cnt_q} + 1'b1) >= (ARM_CNT_W + 1)'(ARM_HOLD_FRAMES));

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_DISARMED;
      arm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
    end
  end

  // failsafe is checked first, then arm_req, then the tick. This order makes an
  // arm completion that collides with a disarm or a fault lose.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    unique case (state_q)
      ST_DISARMED: begin
        if (failsafe) begin
          state_d = ST_FAULT;
        end else if (frame_tick && arm_req && cmds_zero) begin
          state_d   = ST_ARMING;
          arm_cnt_d = '0;
        end
      end
      ST_ARMING: begin
        if (failsafe) begin
          state_d = ST_FAULT;
        end else if (!arm_req) begin
          state_d = ST_DISARMED;
        end else if (frame_tick) begin
          arm_cnt_d = arm_cnt_q + 1'b1;
          if (arm_done) begin
            state_d = ST_ARMED;
          end
        end
      end
      ST_ARMED: begin
        if (failsafe) begin
          state_d = ST_FAULT;
        end else if (!arm_req) begin
          state_d = ST_DISARMED;
        end
      end
      ST_FAULT: begin
        if (!failsafe && !arm_req) begin
          state_d = ST_DISARMED;
        end
      end
    endcase
  end

  assign state = state_q;
  assign armed = (state_q == ST_ARMED);

  // Rate channels. A rate is cleared whenever the next state is not ARMED, so
  // disarm and fault zero the outputs on the same edge as the state change.
  // Steps happen only on frame_tick edges that begin and end in ARMED.
  logic                  rate_clr;
  logic                  rate_step;
  logic [RATE_WIDTH-1:0] cmd_arr  [4];
  logic [RATE_WIDTH-1:0] rate_arr [4];

  assign rate_clr  = (state_d != ST_ARMED);
  assign rate_step = frame_tick && (state_q == ST_ARMED);

  assign cmd_arr[0] = motor_1_cmd;
  assign cmd_arr[1] = motor_2_cmd;
  assign cmd_arr[2] = motor_3_cmd;
  assign cmd_arr[3] = motor_4_cmd;

  for (genvar i = 0; i < 4; i++) begin : g_chan
    rate_slew_limiter #(
      .RATE_WIDTH (RATE_WIDTH),
      .SLEW_STEP  (SLEW_STEP)
    ) u_slew (
      .us_clk  (us_clk),
      .resetn  (resetn),
      .clr     (rate_clr),
      .step_en (rate_step),
      .cmd     (cmd_arr[i]),
      .rate    (rate_arr[i])
    );
  end

  assign motor_1_rate = rate_arr[0];
  assign motor_2_rate = rate_arr[1];
  assign motor_3_rate = rate_arr[2];
  assign motor_4_rate = rate_arr[3];

endmodule

// File: tb/tb_esc_arming_sequencer.sv
// Self-checking bench for esc_arming_sequencer: directed scenarios plus a randomized run against a frame-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_esc_arming_sequencer;

  localparam int RW   = 8;
  localparam int HOLD = 3;
  localparam int STEP = 8;
  localparam int P    = int'(esc_arming_sequencer_pkg::FRAME_CNT_MAX);

  logic          us_clk = 1'b0;
  logic          resetn = 1'b0;
  logic [RW-1:0] motor_1_cmd = '0, motor_2_cmd = '0, motor_3_cmd = '0, motor_4_cmd = '0;
  logic          arm_req = 1'b0, failsafe = 1'b0;
  logic [RW-1:0] motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate;
  logic          armed, frame_tick;
  logic [1:0]    state;
  logic [RW-1:0] r [4];

  assign r[0] = motor_1_rate;
  assign r[1] = motor_2_rate;
  assign r[2] = motor_3_rate;
  assign r[3] = motor_4_rate;

  esc_arming_sequencer #(
    .RATE_WIDTH      (RW),
    .ARM_HOLD_FRAMES (HOLD),
    .SLEW_STEP       (STEP)
  ) dut (
    .us_clk       (us_clk),
    .resetn       (resetn),
    .motor_1_cmd  (motor_1_cmd),
    .motor_2_cmd  (motor_2_cmd),
    .motor_3_cmd  (motor_3_cmd),
    .motor_4_cmd  (motor_4_cmd),
    .arm_req      (arm_req),
    .failsafe     (failsafe),
    .motor_1_rate (motor_1_rate),
    .motor_2_rate (motor_2_rate),
    .motor_3_rate (motor_3_rate),
    .motor_4_rate (motor_4_rate),
    .armed        (armed),
    .state        (state),
    .frame_tick   (frame_tick)
  );

  always #5 us_clk = ~us_clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: 0=DISARMED 1=ARMING 2=ARMED 3=FAULT, cycle position in the frame.
  int m_st = 0, m_cnt = 0, m_cyc = 0;
  int m_rate [4] = '{0, 0, 0, 0};
  bit m_was_tick = 1'b0;

  function automatic int slew(input int rate, input int cmd);
`ifdef SLEW_LIMIT_EN
    if (cmd - rate > STEP) return rate + STEP;
    if (rate - cmd > STEP) return rate - STEP;
    return cmd;
`else
    return cmd + 0 * rate;
`endif
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_cyc = 0;
    for (int i = 0; i < 4; i++) m_rate[i] = 0;
  endtask

  task automatic model_edge();
    int cmd [4];
    bit tick;
    bit allz;
    cmd[0] = int'(motor_1_cmd); cmd[1] = int'(motor_2_cmd);
    cmd[2] = int'(motor_3_cmd); cmd[3] = int'(motor_4_cmd);
    tick = (m_cyc == P);
    allz = (cmd[0] == 0) && (cmd[1] == 0) && (cmd[2] == 0) && (cmd[3] == 0);
    m_was_tick = tick;
    if (failsafe && m_st != 3) m_st = 3;
    else if (m_st == 3) begin
      if (!failsafe && !arm_req) m_st = 0;
    end else if ((m_st == 1 || m_st == 2) && !arm_req) m_st = 0;
    else if (tick) begin
      case (m_st)
        0: if (arm_req && allz) begin m_st = 1; m_cnt = 0; end
        1: begin m_cnt++; if (m_cnt >= HOLD) m_st = 2; end
        2: for (int i = 0; i < 4; i++) m_rate[i] = slew(m_rate[i], cmd[i]);
        default: ;
      endcase
    end
    if (m_st != 2) for (int i = 0; i < 4; i++) m_rate[i] = 0;
    m_cyc = tick ? 0 : m_cyc + 1;
  endtask

  // One clock: inputs were set at the previous negedge; outputs observed at the next negedge.
  task automatic cyc1();
    @(posedge us_clk);
    model_edge();
    @(negedge us_clk);
  endtask

  // Advance until an edge that consumed a frame tick (bounded by one frame).
  task automatic next_tick();
    for (int i = 0; i <= P + 1; i++) begin
      cyc1();
      if (m_was_tick) break;
    end
  endtask

  task automatic set_cmds(input int v);
    motor_1_cmd = RW'(v); motor_2_cmd = RW'(v); motor_3_cmd = RW'(v); motor_4_cmd = RW'(v);
  endtask

  task automatic test_reset();
    @(negedge us_clk);
    #1;
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state); end
    vectors++; if (armed !== 1'b0) begin miscompares++; $display("FAIL reset_armed: got %0b want 0", armed); end
    vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %0b want 0", frame_tick); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (r[i] !== '0) begin miscompares++; $display("FAIL reset_rate%0d: got %0d want 0", i + 1, r[i]); end
    end
    @(negedge us_clk);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_arm();
    arm_req = 1'b1; set_cmds(0);
    next_tick();
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL arm_enter: state %0d want 1", state); end
    next_tick(); next_tick();
    vectors++; if (state !== 2'd1 || armed !== 1'b0) begin miscompares++; $display("FAIL arm_hold: state %0d armed %0b want 1/0", state, armed); end
    next_tick();
    vectors++; if (state !== 2'd2 || armed !== 1'b1) begin miscompares++; $display("FAIL arm_done: state %0d armed %0b want 2/1", state, armed); end
  endtask

  task automatic test_slew();
    int up [3];
    int dn [3];
`ifdef SLEW_LIMIT_EN
    up = '{8, 16, 20}; dn = '{12, 4, 0};
`else
    up = '{20, 20, 20}; dn = '{0, 0, 0};
`endif
    set_cmds(20);
    cyc1();
    vectors++; if (r[0] !== '0) begin miscompares++; $display("FAIL slew_between_ticks: rate %0d want 0", r[0]); end
    for (int k = 0; k < 3; k++) begin
      next_tick();
      for (int i = 0; i < 4; i++) begin
        vectors++; if (r[i] !== RW'(up[k])) begin miscompares++; $display("FAIL slew_up%0d_m%0d: rate %0d want %0d", k, i + 1, r[i], up[k]); end
      end
    end
    set_cmds(0);
    for (int k = 0; k < 3; k++) begin
      next_tick();
      for (int i = 0; i < 4; i++) begin
        vectors++; if (r[i] !== RW'(dn[k])) begin miscompares++; $display("FAIL slew_dn%0d_m%0d: rate %0d want %0d", k, i + 1, r[i], dn[k]); end
      end
    end
  endtask

  task automatic test_disarm();
    set_cmds(200);
    for (int k = 0; k < 30; k++) next_tick();
    vectors++; if (r[2] !== RW'(200)) begin miscompares++; $display("FAIL disarm_ramp: rate %0d want 200", r[2]); end
    cyc1();
    arm_req = 1'b0;
    cyc1();
    vectors++; if (frame_tick !== 1'b0) begin miscompares++; $display("FAIL disarm_no_tick: tick %0b want 0", frame_tick); end
    vectors++; if (state !== 2'd0 || armed !== 1'b0) begin miscompares++; $display("FAIL disarm_state: state %0d armed %0b want 0/0", state, armed); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (r[i] !== '0) begin miscompares++; $display("FAIL disarm_rate%0d: got %0d want 0", i + 1, r[i]); end
    end
    set_cmds(0);
  endtask

  task automatic test_interlock();
    arm_req = 1'b1; motor_2_cmd = RW'(10);
    for (int k = 0; k < 5; k++) begin
      next_tick();
      vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL interlock_tick%0d: state %0d want 0", k, state); end
    end
    motor_2_cmd = '0;
    next_tick();
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL interlock_release: state %0d want 1", state); end
  endtask

  task automatic test_collision();
    next_tick(); next_tick();
    while (m_cyc != P) cyc1();
    arm_req = 1'b0;
    cyc1();
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL collide_disarm: state %0d want 0", state); end
    arm_req = 1'b1;
    next_tick(); next_tick(); next_tick();
    while (m_cyc != P) cyc1();
    failsafe = 1'b1;
    cyc1();
    vectors++; if (state !== 2'd3 || armed !== 1'b0) begin miscompares++; $display("FAIL collide_fault: state %0d armed %0b want 3/0", state, armed); end
  endtask

  task automatic test_failsafe();
    int exp_r;
`ifdef SLEW_LIMIT_EN
    exp_r = 16;
`else
    exp_r = 100;
`endif
    failsafe = 1'b0; arm_req = 1'b0;
    cyc1();
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL fault_exit: state %0d want 0", state); end
    arm_req = 1'b1;
    for (int k = 0; k < 4; k++) next_tick();
    set_cmds(100);
    next_tick(); next_tick();
    vectors++; if (r[1] !== RW'(exp_r)) begin miscompares++; $display("FAIL fs_ramp: rate %0d want %0d", r[1], exp_r); end
    for (int k = 0; k < 10; k++) cyc1();
    failsafe = 1'b1;
    cyc1();
    vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL fs_enter: state %0d want 3", state); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (r[i] !== '0) begin miscompares++; $display("FAIL fs_rate%0d: got %0d want 0", i + 1, r[i]); end
    end
    failsafe = 1'b0; set_cmds(0);
    cyc1(); cyc1(); next_tick();
    vectors++; if (state !== 2'd3) begin miscompares++; $display("FAIL fs_hold: state %0d want 3", state); end
    arm_req = 1'b0;
    cyc1();
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL fs_release: state %0d want 0", state); end
  endtask

  task automatic test_reset_mid_ramp();
    int found;
    arm_req = 1'b1;
    for (int k = 0; k < 4; k++) next_tick();
    set_cmds(50);
    next_tick(); next_tick();
    for (int k = 0; k < 7; k++) cyc1();
    #2 resetn = 1'b0;
    #1;
    vectors++; if (state !== 2'd0 || armed !== 1'b0) begin miscompares++; $display("FAIL rst_async_state: state %0d armed %0b want 0/0", state, armed); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (r[i] !== '0) begin miscompares++; $display("FAIL rst_async_rate%0d: got %0d want 0", i + 1, r[i]); end
    end
    model_reset();
    set_cmds(0);
    @(negedge us_clk);
    resetn = 1'b1;
    found = -1;
    for (int k = 1; k <= P + 1; k++) begin
      cyc1();
      if (frame_tick === 1'b1 && found < 0) found = k;
    end
    vectors++; if (found != P) begin miscompares++; $display("FAIL rst_first_tick: edge %0d want %0d", found, P); end
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL rearm_enter: state %0d want 1", state); end
    next_tick(); next_tick();
    vectors++; if (state !== 2'd1) begin miscompares++; $display("FAIL rearm_hold: state %0d want 1", state); end
    next_tick();
    vectors++; if (state !== 2'd2) begin miscompares++; $display("FAIL rearm_done: state %0d want 2", state); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 15000; n++) begin
      if ($urandom_range(0, 2999) == 0) arm_req = ~arm_req;
      if (!failsafe && $urandom_range(0, 3999) == 0) failsafe = 1'b1;
      else if (failsafe && $urandom_range(0, 99) == 0) failsafe = 1'b0;
      if ($urandom_range(0, 149) == 0) begin
        if ($urandom_range(0, 1) == 0) set_cmds(0);
        else begin
          motor_1_cmd = RW'($urandom); motor_2_cmd = RW'($urandom);
          motor_3_cmd = RW'($urandom); motor_4_cmd = RW'($urandom);
        end
      end
      cyc1();
      vectors++; if (state !== 2'(m_st)) begin miscompares++; $display("FAIL rnd_state@%0d: got %0d want %0d", n, state, m_st); end
      vectors++; if (armed !== (m_st == 2)) begin miscompares++; $display("FAIL rnd_armed@%0d: got %0b want %0b", n, armed, m_st == 2); end
      vectors++; if (frame_tick !== (m_cyc == P)) begin miscompares++; $display("FAIL rnd_tick@%0d: got %0b want %0b", n, frame_tick, m_cyc == P); end
      for (int i = 0; i < 4; i++) begin
        vectors++; if (r[i] !== RW'(m_rate[i])) begin miscompares++; $display("FAIL rnd_rate%0d@%0d: got %0d want %0d", i + 1, n, r[i], m_rate[i]); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arm();
    test_slew();
    test_disarm();
    test_interlock();
    test_collision();
    test_failsafe();
    test_reset_mid_ramp();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
